// File: rtl/nios_system_jtag_debug_cmd_router.sv
// Routes JTAG debug commands captured in the TCK domain to per-core channels
// with a valid/ready handshake, sticky error flags and an accept counter.
module nios_system_jtag_debug_cmd_router #(
  parameter int SR_WIDTH   = 38,
  parameter int IR_WIDTH   = 2,
  parameter int CH_COUNT   = 4,
  parameter int CH_SEL_W   = 2,
  parameter int ACTION_BIT = 35
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [SR_WIDTH-1:0]          sr,
  input  logic [IR_WIDTH-1:0]          ir_in,
  input  logic                         vs_udr,
  input  logic                         vs_uir,
  input  logic [CH_COUNT-1:0]          cmd_ready,
  input  logic                         status_clear,
  output logic [CH_COUNT-1:0]          cmd_valid,
  output logic [CH_COUNT*SR_WIDTH-1:0] cmd_data,
  output logic [CH_COUNT*IR_WIDTH-1:0] cmd_code,
  output logic [CH_COUNT-1:0]          cmd_act,
  output logic                         ir_update,
  output logic [CH_COUNT-1:0]          overflow,
  output logic                         bad_ch,
  output logic [15:0]                  cmd_count
);

  localparam logic [CH_SEL_W:0] CH_LIMIT = (CH_SEL_W+1)'(CH_COUNT);

  logic [2:0]                   udr_sync_q;
  logic [2:0]                   uir_sync_q;
  logic [CH_COUNT-1:0]          cmd_valid_q;
  logic [CH_COUNT*SR_WIDTH-1:0] cmd_data_q;
  logic [CH_COUNT*IR_WIDTH-1:0] cmd_code_q;
  logic [CH_COUNT-1:0]          cmd_act_q;
  logic                         ir_update_q;
  logic [CH_COUNT-1:0]          overflow_q;
  logic                         bad_ch_q;
  logic [15:0]                  cmd_count_q;
  logic [15:0]                  cmd_count_d;

  logic                         udr_edge_s;
  logic                         uir_edge_s;
  logic [CH_SEL_W-1:0]          ch_sel_s;
  logic                         ch_ok_s;
  logic [CH_COUNT-1:0]          accept_s;
  logic [CH_COUNT-1:0]          drop_s;
  logic                         bad_s;

  // Sync chains preset to 1 so a level already high at reset release is not an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      udr_sync_q <= 3'b111;
      uir_sync_q <= 3'b111;
    end else begin
      udr_sync_q <= {udr_sync_q[1:0], vs_udr};
      uir_sync_q <= {uir_sync_q[1:0], vs_uir};
    end
  end

  assign udr_edge_s = udr_sync_q[1] & ~udr_sync_q[2];
  assign uir_edge_s = uir_sync_q[1] & ~uir_sync_q[2];
  assign ch_sel_s   = sr[SR_WIDTH-1 -: CH_SEL_W];
  assign ch_ok_s    = ({1'b0, ch_sel_s} < CH_LIMIT);

  // Per-channel accept/drop decision for the command captured this cycle
  always_comb begin
    accept_s = '0;
    drop_s   = '0;
    for (int c = 0; c < CH_COUNT; c++) begin
      accept_s[c] = udr_edge_s & ch_ok_s & (ch_sel_s == CH_SEL_W'(c))
                    & (~cmd_valid_q[c] | cmd_ready[c]);
      drop_s[c]   = udr_edge_s & ch_ok_s & (ch_sel_s == CH_SEL_W'(c))
                    & cmd_valid_q[c] & ~cmd_ready[c];
    end
    bad_s       = udr_edge_s & ~ch_ok_s;
    cmd_count_d = cmd_count_q + {15'd0, |accept_s};
  end

  // Channel payload registers and handshake; a same-edge accept keeps valid high
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_valid_q <= '0;
      cmd_data_q  <= '0;
      cmd_code_q  <= '0;
      cmd_act_q   <= '0;
    end else begin
      for (int c = 0; c < CH_COUNT; c++) begin
        if (accept_s[c]) begin
          cmd_valid_q[c]                       <= 1'b1;
          cmd_data_q[c*SR_WIDTH +: SR_WIDTH]   <= sr;
          cmd_code_q[c*IR_WIDTH +: IR_WIDTH]   <= ir_in;
          cmd_act_q[c]                         <= sr[ACTION_BIT];
        end else if (cmd_ready[c]) begin
          cmd_valid_q[c] <= 1'b0;
        end else begin
          cmd_valid_q[c] <= cmd_valid_q[c];
        end
      end
    end
  end

  // Sticky flags (set beats clear), IR pulse and accept counter
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= '0;
      bad_ch_q    <= 1'b0;
      ir_update_q <= 1'b0;
      cmd_count_q <= 16'd0;
    end else begin
      overflow_q  <= drop_s | (overflow_q & {CH_COUNT{~status_clear}});
      bad_ch_q    <= bad_s | (bad_ch_q & ~status_clear);
      ir_update_q <= uir_edge_s;
      cmd_count_q <= cmd_count_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_data  = cmd_data_q;
  assign cmd_code  = cmd_code_q;
  assign cmd_act   = cmd_act_q;
  assign ir_update = ir_update_q;
  assign overflow  = overflow_q;
  assign bad_ch    = bad_ch_q;
  assign cmd_count = cmd_count_q;

endmodule
